// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller.
// master = datapath side, slave = controller side.
interface multicycle_control_if;
  logic [10:0] Opcode;
  logic        Zero;
  logic        IMemReady;
  logic        DMemReady;
  logic        IMemReq;
  logic        IRWrite;
  logic [2:0]  SignExtCtrl;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic        DMemReq;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic        Illegal;
  logic [2:0]  State;
  logic [31:0] RetireCount;

  modport master (
    output Opcode, Zero, IMemReady, DMemReady,
    input  IMemReq, IRWrite, SignExtCtrl, ALUSrc,
    input  ALUOp, DMemReq, MemWrite, MemtoReg,
    input  RegWrite, PCWrite, PCSrc, Illegal,
    input  State, RetireCount
  );

  modport slave (
    input  Opcode, Zero, IMemReady, DMemReady,
    output IMemReq, IRWrite, SignExtCtrl, ALUSrc,
    output ALUOp, DMemReq, MemWrite, MemtoReg,
    output RegWrite, PCWrite, PCSrc, Illegal,
    output State, RetireCount
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle controller: FETCH/DECODE/EXEC/ADDR/MEM/WB/BRANCH FSM
// with registered sign-extend select and a retired-instruction counter.
module multicycle_control (
  input logic CLK,
  input logic Reset,
  multicycle_control_if.slave bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_ADDR   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_BRANCH = 3'd6;

  localparam logic [2:0] C_R   = 3'd0;
  localparam logic [2:0] C_I   = 3'd1;
  localparam logic [2:0] C_LD  = 3'd2;
  localparam logic [2:0] C_ST  = 3'd3;
  localparam logic [2:0] C_B   = 3'd4;
  localparam logic [2:0] C_CB  = 3'd5;
  localparam logic [2:0] C_IM  = 3'd6;
  localparam logic [2:0] C_ILL = 3'd7;

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [2:0]  cls;
  logic [2:0]  dec;
  logic [2:0]  sext;
  logic [31:0] retire_cnt;

  logic        imem_req;
  logic        ir_write;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        dmem_req;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        pc_write;
  logic        pc_src;
  logic        illegal;

  // Opcode class decode
  always_comb begin
    dec = C_ILL;
    unique casez (bus.Opcode)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec = C_R;
      11'b1001000100?,
      11'b1101000100?: dec = C_I;
      11'b11111000010: dec = C_LD;
      11'b11111000000: dec = C_ST;
      11'b000101?????: dec = C_B;
      11'b10110100???: dec = C_CB;
      11'b110100101??: dec = C_IM;
      default:         dec = C_ILL;
    endcase
  end

  // Next-state logic; code 7 falls back to FETCH
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:
        nxt = bus.IMemReady ? S_DECODE : S_FETCH;
      S_DECODE:
        case (dec)
          C_R, C_I, C_IM: nxt = S_EXEC;
          C_LD, C_ST:     nxt = S_ADDR;
          C_B, C_CB:      nxt = S_BRANCH;
          default:        nxt = S_FETCH;
        endcase
      S_EXEC:   nxt = S_WB;
      S_ADDR:   nxt = S_MEM;
      S_MEM:
        if (!bus.DMemReady) nxt = S_MEM;
        else if (cls == C_LD) nxt = S_WB;
        else nxt = S_FETCH;
      S_WB:     nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // Control outputs per state, forced low while Reset is high
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    dmem_req   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    if (!Reset) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = bus.IMemReady;
        end
        S_DECODE: begin
          if (dec == C_ILL) begin
            illegal  = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          alu_src = (cls == C_I) || (cls == C_IM);
          if (cls == C_R) alu_op = 2'b10;
          else if (cls == C_IM) alu_op = 2'b01;
          else alu_op = 2'b00;
        end
        S_ADDR: begin
          alu_src = 1'b1;
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          mem_write = (cls == C_ST);
          pc_write  = bus.DMemReady && (cls == C_ST);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls == C_LD);
          pc_write   = 1'b1;
        end
        S_BRANCH: begin
          alu_op   = 2'b01;
          pc_write = 1'b1;
          pc_src   = (cls == C_B) ? 1'b1 : bus.Zero;
        end
        default: ;
      endcase
    end
  end

  // State and latched instruction class
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_FETCH;
      cls   <= C_R;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls <= dec;
    end
  end

  // Sign-extend select, held from one DECODE to the next
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sext <= 3'b000;
    end else if (state == S_DECODE) begin
      case (dec)
        C_I:        sext <= 3'b000;
        C_LD, C_ST: sext <= 3'b001;
        C_B:        sext <= 3'b010;
        C_CB:       sext <= 3'b011;
        C_IM:       sext <= 3'b100;
        default:    sext <= sext;
      endcase
    end
  end

  // Retired-instruction counter; skipped opcodes do not count
  always_ff @(posedge CLK) begin
    if (Reset) begin
      retire_cnt <= 32'd0;
    end else if (pc_write && !illegal) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign bus.IMemReq     = imem_req;
  assign bus.IRWrite     = ir_write;
  assign bus.SignExtCtrl = sext;
  assign bus.ALUSrc      = alu_src;
  assign bus.ALUOp       = alu_op;
  assign bus.DMemReq     = dmem_req;
  assign bus.MemWrite    = mem_write;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegWrite    = reg_write;
  assign bus.PCWrite     = pc_write;
  assign bus.PCSrc       = pc_src;
  assign bus.Illegal     = illegal;
  assign bus.State       = state;
  assign bus.RetireCount = retire_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction vector table
// with scoreboard, plus reset-in-MEM and counter-wrap sequences.
module tb_multicycle_control;

  logic CLK = 1'b0;
  logic Reset;

  multicycle_control_if bus();

  multicycle_control dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         lat;
    logic [2:0] sext;
    logic       pcsrc;
    logic       rw;
    logic       mtr;
    logic       ill;
    int         memc;
    logic       mw;
    logic       has_ex;
    logic       alusrc;
    logic [1:0] aluop;
  } exp_t;

  typedef struct {
    logic [10:0] op;
    logic        zero;
    int          iw;
    int          dw;
    bit          keep;
    exp_t        e;
  } vec_t;

  localparam int NV = 16;

  vec_t        tbl [NV];
  exp_t        sb [$];
  int          pass_n = 0;
  int          total_n = 0;
  logic [31:0] exp_ret = 32'd0;
  logic [2:0]  sext_m = 3'b000;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   ireq;
    int   dreq;
    int   irw;
    bit   done;
    e = v.e;
    if (v.keep) e.sext = sext_m;
    else sext_m = e.sext;
    sb.push_back(e);
    got = '{default: 0};
    bus.Opcode = v.op;
    bus.Zero = v.zero;
    ireq = 0;
    dreq = 0;
    irw = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      bus.IMemReady = bus.IMemReq && (ireq >= v.iw);
      if (bus.IMemReq) ireq++;
      bus.DMemReady = bus.DMemReq && (dreq >= v.dw);
      if (bus.DMemReq) dreq++;
      #1;
      got.lat++;
      if (bus.IRWrite) irw++;
      if (bus.State == 3'd2) begin
        got.has_ex = 1'b1;
        got.alusrc = bus.ALUSrc;
        got.aluop = bus.ALUOp;
      end
      if (bus.RegWrite) begin
        got.rw = 1'b1;
        got.mtr = bus.MemtoReg;
      end
      if (bus.DMemReq) begin
        got.memc++;
        got.mw = bus.MemWrite;
      end
      if (bus.Illegal) got.ill = 1'b1;
      if (bus.PCWrite) begin
        got.pcsrc = bus.PCSrc;
        got.sext = bus.SignExtCtrl;
        done = 1;
      end
    end
    if (!done) begin
      total_n++;
      $display("FAIL %s.timeout: got no PCWrite expected one", tag);
    end
    e = sb.pop_front();
    chk({tag, ".lat"}, got.lat, e.lat);
    chk({tag, ".sext"}, got.sext, e.sext);
    chk({tag, ".pcsrc"}, got.pcsrc, e.pcsrc);
    chk({tag, ".regwr"}, got.rw, e.rw);
    chk({tag, ".memtoreg"}, got.mtr, e.mtr);
    chk({tag, ".illegal"}, got.ill, e.ill);
    chk({tag, ".memcyc"}, got.memc, e.memc);
    chk({tag, ".memwr"}, got.mw, e.mw);
    chk({tag, ".irwrite"}, irw, 1);
    chk({tag, ".exec"}, got.has_ex, e.has_ex);
    if (e.has_ex) begin
      chk({tag, ".alusrc"}, got.alusrc, e.alusrc);
      chk({tag, ".aluop"}, got.aluop, e.aluop);
    end
    if (!e.ill) exp_ret = exp_ret + 32'd1;
    @(posedge CLK);
    #1;
    bus.IMemReady = 1'b0;
    bus.DMemReady = 1'b0;
    chk({tag, ".state"}, bus.State, 0);
    chk({tag, ".retire"}, bus.RetireCount, exp_ret);
  endtask

  initial begin
    // op, zero, iw, dw, keep,
    // {lat,sext,pcsrc,rw,mtr,ill,memc,mw,has_ex,alusrc,aluop}
    tbl[0]  = '{11'b10010001000, 0, 0, 0, 0,
                '{4, 3'b000, 0, 1, 0, 0, 0, 0, 1, 1, 2'b00}};
    tbl[1]  = '{11'b10010001000, 0, 2, 0, 0,
                '{6, 3'b000, 0, 1, 0, 0, 0, 0, 1, 1, 2'b00}};
    tbl[2]  = '{11'b10001011000, 0, 0, 0, 1,
                '{4, 3'b000, 0, 1, 0, 0, 0, 0, 1, 0, 2'b10}};
    tbl[3]  = '{11'b11111000010, 0, 0, 2, 0,
                '{7, 3'b001, 0, 1, 1, 0, 3, 0, 0, 0, 2'b00}};
    tbl[4]  = '{11'b11111000000, 0, 0, 0, 0,
                '{4, 3'b001, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00}};
    tbl[5]  = '{11'b10110100000, 0, 0, 0, 0,
                '{3, 3'b011, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00}};
    tbl[6]  = '{11'b10110100000, 1, 0, 0, 0,
                '{3, 3'b011, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00}};
    tbl[7]  = '{11'b11010010100, 0, 0, 0, 0,
                '{4, 3'b100, 0, 1, 0, 0, 0, 0, 1, 1, 2'b01}};
    tbl[8]  = '{11'b00000000000, 0, 0, 0, 1,
                '{2, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00}};
    tbl[9]  = '{11'b00010100000, 0, 0, 0, 0,
                '{3, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00}};
    tbl[10] = '{11'b11010001001, 0, 0, 0, 0,
                '{4, 3'b000, 0, 1, 0, 0, 0, 0, 1, 1, 2'b00}};
    tbl[11] = '{11'b10101010000, 0, 0, 0, 1,
                '{4, 3'b000, 0, 1, 0, 0, 0, 0, 1, 0, 2'b10}};
    tbl[12] = '{11'b11111000000, 0, 1, 1, 0,
                '{6, 3'b001, 0, 0, 0, 0, 2, 1, 0, 0, 2'b00}};
    tbl[13] = '{11'b11001011000, 1, 0, 0, 1,
                '{4, 3'b000, 0, 1, 0, 0, 0, 0, 1, 0, 2'b10}};
    tbl[14] = '{11'b10001010000, 0, 0, 0, 1,
                '{4, 3'b000, 0, 1, 0, 0, 0, 0, 1, 0, 2'b10}};
    tbl[15] = '{11'b11111111111, 0, 0, 0, 1,
                '{2, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00}};

    Reset = 1'b1;
    bus.Opcode = 11'd0;
    bus.Zero = 1'b0;
    bus.IMemReady = 1'b0;
    bus.DMemReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst.state", bus.State, 0);
    chk("rst.retire", bus.RetireCount, 0);
    chk("rst.sext", bus.SignExtCtrl, 0);
    chk("rst.imemreq", bus.IMemReq, 1);
    chk("rst.pcwrite", bus.PCWrite, 0);
    chk("rst.regwrite", bus.RegWrite, 0);
    chk("rst.illegal", bus.Illegal, 0);

    for (int i = 0; i < NV; i++)
      run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset while a store waits in MEM
    bus.Opcode = 11'b11111000000;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      bus.IMemReady = bus.IMemReq;
      bus.DMemReady = 1'b0;
      #1;
      if (bus.State == 3'd4) break;
    end
    chk("stmem.state", bus.State, 4);
    chk("stmem.memwr", bus.MemWrite, 1);
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    chk("stmem.rst_pcw", bus.PCWrite, 0);
    chk("stmem.rst_rw", bus.RegWrite, 0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    chk("stmem.state0", bus.State, 0);
    chk("stmem.memwr0", bus.MemWrite, 0);
    chk("stmem.pcw0", bus.PCWrite, 0);
    chk("stmem.retire0", bus.RetireCount, 0);
    chk("stmem.sext0", bus.SignExtCtrl, 0);
    exp_ret = 32'd0;
    sext_m = 3'b000;

    // Counter wrap on a branch
    force dut.retire_cnt = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.retire_cnt;
    exp_ret = 32'hFFFF_FFFF;
    run_vec(tbl[9], "wrap");
    chk("wrap.zero", bus.RetireCount, 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
